// File: rtl/serial_sign_convert.sv
// serial_sign_convert
//   Bit-serial converter between two's complement (TC) and sign-magnitude (SM).
//   mode=0 converts TC->SM, mode=1 converts SM->TC; the direction is captured
//   together with the word at accept time.
//
//   The magnitude is resolved one bit per clock. Each bit is conditionally
//   inverted by the sign and then passed through one half adder whose carry
//   is the only arithmetic state. For a negative input this computes
//   ~x + 1 over the magnitude bits. A positive input passes through
//   unchanged because the inversion is off and the carry starts at 0.
//
//   Handshake semantics (both ports):
//     A transfer happens on a rising clk edge where valid && ready are both 1.
//     in_ready is high only in IDLE, so the converter holds one word at a time.
//     out_valid is high only in DONE. While out_ready is 0, out_data, out_ovf
//     and out_negz stay stable. in_data and mode are ignored outside the
//     accept edge.
//
//   Optional build macro: SERIAL_SIGN_CONVERT_SAT_EN
//     defined   : a TC->SM overflow (input -2^(N-1)) returns {1, all ones}
//     undefined : a TC->SM overflow returns the raw result {1, zeros}
//     out_ovf is 1 for this input in both builds.
//
//   The FSM state is held in the named signal 'state' so checkers can bind
//   to it.

module serial_sign_convert #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf,
    output logic         out_negz
);

    // The counter walks the magnitude bits 0..N-2.
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured transaction.
    logic [N-1:0]  data_q;
    logic          mode_q;
    logic          sign_q;

    // Serial engine.
    logic          carry_q;
    logic [CW-1:0] cnt_q;

    // Result registers.
    logic [N-1:0]  out_data_q;
    logic          ovf_q;
    logic          negz_q;

    // Per-bit datapath signals.
    logic          accept;
    logic          last_bit;
    logic          a_bit;
    logic          sum_bit;
    logic          carry_nxt;

    // Values committed at the RUN->DONE edge.
    logic          msb_fin;
    logic          ovf_fin;
    logic          negz_fin;

    assign accept   = in_valid && in_ready;
    assign last_bit = (state == RUN) && (cnt_q == LAST_BIT);

    // Half adder on the sign-conditioned input bit.
    always_comb begin
        a_bit     = data_q[cnt_q] ^ sign_q;
        sum_bit   = a_bit ^ carry_q;
        carry_nxt = a_bit & carry_q;
    end

    // MSB and flag resolution from the carry that leaves the last magnitude bit.
    // A surviving carry means every magnitude bit was 0:
    //   TC->SM: the input was 100..0, which has no SM equivalent.
    //   SM->TC: the input was negative zero, which maps to TC 0.
    always_comb begin
        msb_fin  = sign_q;
        ovf_fin  = 1'b0;
        negz_fin = 1'b0;
        if (mode_q == 1'b0) begin
            msb_fin = sign_q;
            ovf_fin = sign_q & carry_nxt;
        end else begin
            msb_fin  = sign_q ^ carry_nxt;
            negz_fin = sign_q & carry_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_BIT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture on accept, then produce one result bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            mode_q     <= 1'b0;
            sign_q     <= 1'b0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
            negz_q     <= 1'b0;
        end else if (accept) begin
            data_q     <= in_data;
            mode_q     <= mode;
            sign_q     <= in_data[N-1];
            carry_q    <= in_data[N-1];
            cnt_q      <= '0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
            negz_q     <= 1'b0;
        end else if (state == RUN) begin
            out_data_q[cnt_q] <= sum_bit;
            carry_q           <= carry_nxt;
            if (last_bit) begin
                out_data_q[N-1] <= msb_fin;
                ovf_q           <= ovf_fin;
                negz_q          <= negz_fin;
`ifdef SERIAL_SIGN_CONVERT_SAT_EN
                // Largest SM magnitude with negative sign replaces -2^(N-1).
                if (ovf_fin) begin
                    out_data_q <= {1'b1, {(N-1){1'b1}}};
                end
`endif
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out_data = out_data_q;
    assign out_ovf  = ovf_q;
    assign out_negz = negz_q;

endmodule

// File: tb/tb_serial_sign_convert.sv
// Testbench for serial_sign_convert (N=8).
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge.
// Directed cases use constant expectations. Random cases use a reference
// function that converts with plain arithmetic.

module tb_serial_sign_convert;

    localparam int N = 8;
    localparam int TIMEOUT = 50;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_ovf;
    logic         out_negz;

    int checks;
    int failures;

    serial_sign_convert #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_negz  (out_negz)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {ovf, negz, data}. This is plain integer math on the
    // numeric value, not a bit-serial model.
    function automatic logic [N+1:0] ref_conv(input logic m, input logic [N-1:0] d);
        int unsigned w;
        int unsigned half;
        int unsigned du;
        int unsigned mag;
        int unsigned res;
        logic        ovf;
        logic        negz;
        logic [N-1:0] r;
        w    = 1 << N;
        half = 1 << (N - 1);
        du   = int'(d);
        mag  = du % half;
        ovf  = 1'b0;
        negz = 1'b0;
        if (du < half) begin
            res = du;
        end else if (m == 1'b0) begin
            if (du == half) begin
                ovf = 1'b1;
`ifdef SERIAL_SIGN_CONVERT_SAT_EN
                res = w - 1;
`else
                res = half;
`endif
            end else begin
                res = half + (w - du);   // sign bit plus |value|
            end
        end else begin
            if (mag == 0) begin
                negz = 1'b1;
                res  = 0;
            end else begin
                res = w - mag;           // two's complement of -mag
            end
        end
        r = N'(res);
        return {ovf, negz, r};
    endfunction

    // One full transaction. During the stall, out_ready stays low while
    // in_data and in_valid toggle.
    task automatic convert(input logic m, input logic [N-1:0] d,
                           input logic [N-1:0] exp_data, input logic exp_ovf,
                           input logic exp_negz, input int stall, input string tag);
        int cyc;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = N'($urandom);
        mode     = 1'($urandom);
        cyc = 0;
        while (!out_valid && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(N - 1));
        check({tag, "_data"}, 32'(out_data), 32'(exp_data));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        check({tag, "_negz"}, 32'(out_negz), 32'(exp_negz));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'($urandom);
            in_data  = N'($urandom);
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_data"}, 32'(out_data), 32'(exp_data));
            check({tag, "_hold_flags"}, 32'({out_ovf, out_negz}), 32'({exp_ovf, exp_negz}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic convert_ref(input logic m, input logic [N-1:0] d, input int stall, input string tag);
        logic [N+1:0] e;
        e = ref_conv(m, d);
        convert(m, d, e[N-1:0], e[N+1], e[N], stall, tag);
    endtask

    initial begin
        logic [N-1:0] ovf_exp;
        int cyc;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 1'b0;
        out_ready = 1'b0;

        // reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_flags", 32'({out_ovf, out_negz}), 32'd0);

`ifdef SERIAL_SIGN_CONVERT_SAT_EN
        ovf_exp = 8'hFF;
`else
        ovf_exp = 8'h80;
`endif
        // directed conversions
        convert(1'b0, 8'hFB, 8'h85, 1'b0, 1'b0, 0, "tc2sm_m5");
        convert(1'b1, 8'h85, 8'hFB, 1'b0, 1'b0, 0, "sm2tc_m5");
        convert(1'b0, 8'h80, ovf_exp, 1'b1, 1'b0, 0, "tc2sm_min");
        convert(1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 0, "sm2tc_negz");
        convert(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 0, "sm2tc_zero");
        convert(1'b0, 8'h7F, 8'h7F, 1'b0, 1'b0, 0, "tc2sm_max");
        convert(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b0, 0, "sm2tc_max");
        convert(1'b0, 8'hFF, 8'h81, 1'b0, 1'b0, 5, "backpressure");
        convert(1'b1, 8'hFF, 8'h81, 1'b0, 1'b0, 0, "after_bp");

        // reset during RUN at bit 3
        in_valid = 1'b1;
        in_data  = 8'h80;
        mode     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_flags", 32'({out_ovf, out_negz}), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst_no_result", 32'(out_valid), 32'd0);
        convert(1'b0, 8'hFF, 8'h81, 1'b0, 1'b0, 0, "post_rst");

        // random words and modes, with random backpressure
        for (int i = 0; i < 40; i++) begin
            convert_ref(1'($urandom), N'($urandom), $urandom_range(0, 3), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_sign_convert.md
Name: serial_sign_convert

Overview:
- Parametrised, handshaked, bit-serial converter between two's complement (TC) and sign-magnitude (SM), with direction selected per transaction.
- Resolves one magnitude bit per clock through a single registered half-adder carry, trading latency for area.
- Flags the TC value with no SM equivalent and the SM negative-zero encoding.
- Sits between the TC datapath and SM-based display and arithmetic units.

Parameters:
- N, 8, total word width in bits including sign; legal N >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_data/mode valid
- in_ready  output  1  converter can accept a word
- in_data  input  N  word to convert
- mode  input  1  0 = TC->SM, 1 = SM->TC; sampled at accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- out_data  output  N  converted word
- out_ovf  output  1  TC->SM input was -2^(N-1)
- out_negz  output  1  SM->TC input was negative zero (sign 1, magnitude 0)

Behaviour:
- Reset (rst=1 at clk edge): state IDLE. in_ready=1, out_valid=0, out_data=0, out_ovf=0, out_negz=0. Bit counter and carry cleared. Reset overrides all other events, including mid-RUN and DONE; any in-flight word is discarded.
- FSM states:
  - IDLE: in_ready=1. On in_valid & in_ready: latch in_data and mode, set sign s=in_data[N-1], carry=s, counter=0, go to RUN.
  - RUN: in_ready=0. Each cycle process bit i=counter (0..N-2): a=in_data[i]^s, out bit i=a^carry, carry<=a&carry. After bit N-2, go to DONE.
  - DONE: out_valid=1 with all outputs stable. On out_ready, go to IDLE. in_ready=0 in DONE.
- Latency: out_valid is high N-1 clocks after the accepting edge (N=8: 7 cycles). Maximum throughput is one word per N+... cycles, specifically accept edge + N-1 RUN + 1 DONE cycle with out_ready=1, giving N+1 cycles between accepts.
- MSB and flags, evaluated at the RUN->DONE edge with final carry c:
  - TC->SM: out_data[N-1]=s; out_ovf=s&c (input 100..0); out_negz=0.
  - SM->TC: out_data[N-1]=s^c, so negative zero produces 0; out_negz=s&c; out_ovf=0.
  - Positive inputs (s=0) pass through unchanged in both modes.
- Backpressure: DONE holds out_data, out_ovf and out_negz stable for as long as out_ready=0.
- in_valid while not in_ready is ignored. in_data/mode changes during RUN have no effect.
- out_ovf/out_negz are valid only with out_valid. They are cleared on the next accept.

Optional Feature:
- Macro: SERIAL_SIGN_CONVERT_SAT_EN.
- Defined: a TC->SM overflow returns saturated max-magnitude negative {1, all ones} (N=8: 0xFF, i.e. -127); out_ovf is still 1.
- Undefined: a TC->SM overflow returns the raw half-adder result {1, zeros} (N=8: 0x80, SM -0), with out_ovf=1.
- SM->TC behaviour is identical either way.

Test Plan:
- N=8, mode=0, in 0xFB (-5) -> out 0x85, ovf=0, negz=0, out_valid 7 cycles after accept; mode=1, in 0x85 -> out 0xFB.
- Mode=0, in 0x80 -> ovf=1; out 0x80 without SAT_EN, 0xFF with SAT_EN.
- Mode=1, in 0x80 -> out 0x00, negz=1; mode=1, in 0x00 -> out 0x00, negz=0; in 0x7F in both modes -> out 0x7F, flags 0.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_data and in_valid -> outputs stable, in_ready=0, no new accept; then out_ready=1 -> IDLE and next word accepted.
- Assert rst at RUN bit 3 -> next cycle in_ready=1, out_valid=0, outputs 0; a following conversion of 0xFF (mode 0) -> 0x81.
- N=2 and N=16 builds: mode 0 in 0x8000 -> ovf=1; mode 0 in 0xFFFF -> 0x8001; mode 1 in 0x8001 -> 0xFFFF.
